// File: rtl/flygoat_tune_pkg.sv
`default_nettype none
// ============================================================================
// Module : flygoat_tune_pkg
// Brief  : Shared types, widths and the four hard-wired tune tables for the
//          TT02 tune player.
// Rev    : 1.0  initial release
// ============================================================================
package flygoat_tune_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 4;
  localparam int STEPS   = 16;
  localparam int STEP_W  = $clog2(STEPS);
  localparam int HALF_W  = 6;   // half periods reach 32 clocks
  localparam int BEATS_W = 5;   // beat count reaches 16 (dur==0)

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  // Note n=1..15 maps to a half period of 34-2n clocks (32 down to 4).
  function automatic logic [HALF_W-1:0] half_period(input logic [NOTE_W-1:0] note);
    return HALF_W'(34) - {1'b0, note, 1'b0};
  endfunction

  // A stored duration of zero stands for the longest note, 16 beats.
  function automatic logic [BEATS_W-1:0] dur_beats(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? BEATS_W'(16) : {1'b0, dur};
  endfunction

  // Tune ROM: sel picks one of four tunes, idx the entry within it.
  function automatic entry_t tune_entry(input logic [1:0] sel, input logic [STEP_W-1:0] idx);
    entry_t e;
    e.note = '0;
    e.dur  = 4'd1;
    case (sel)
      2'd0: e.note = (idx == 4'd15) ? 4'd0 : idx + 4'd1;
      2'd1: begin
        e.note = (idx == 4'd15) ? 4'd0 : 4'd15 - idx;
        e.dur  = 4'd2;
      end
      2'd2: e.note = idx[0] ? 4'd8 : 4'd1;
      default: e.note = 4'd8;
    endcase
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flygoat_tt02_play_tune_tone_gen.sv
`default_nettype none
// ============================================================================
// Module : tune_tone_gen
// Brief  : Square-wave generator; toggles the tone every i_half clocks while
//          enabled, restarting from a low phase on request.
// Rev    : 1.0  initial release
// ============================================================================
module tune_tone_gen
  import flygoat_tune_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] i_half,
  input  logic              i_en,
  input  logic              i_restart,
  output logic              o_tone
);

  logic [HALF_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              tone_q, tone_d;

  // Next-state: restart and rests park the counter and tone low.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    if (rst || i_restart || !i_en) begin
      tone_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (tone_cnt_q == i_half - HALF_W'(1)) begin
      tone_cnt_d = '0;
      tone_d     = ~tone_q;
    end else begin
      tone_cnt_d = tone_cnt_q + HALF_W'(1);
    end
  end

  // Tone state registers.
  always_ff @(posedge clk) begin
    tone_cnt_q <= tone_cnt_d;
    tone_q     <= tone_d;
  end

  assign o_tone = tone_q;

endmodule
`default_nettype wire

// File: rtl/flygoat_tt02_play_tune.sv
`default_nettype none
// ============================================================================
// Module : flygoat_tt02_play_tune
// Brief  : TT02 tune player top. Beat timer and step sequencer walk a
//          16-entry tune; a tone generator drives a differential speaker.
// Rev    : 1.0  initial release
// ============================================================================
module flygoat_tt02_play_tune
  import flygoat_tune_pkg::*;
#(
  parameter int MAX_COUNT = 10000
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int CNT_W = $clog2(MAX_COUNT);

  logic       clk;
  logic       rst;
  logic [1:0] db_sel;
  logic       unused_io;

  assign clk       = io_in[0];
  assign rst       = io_in[1];
  assign db_sel    = io_in[3:2];
  assign unused_io = &{1'b0, io_in[7:4]};

  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BEATS_W-1:0] beats_left_q, beats_left_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [1:0]         db_q, db_d;
  logic [7:0]         io_out_q, io_out_d;

  entry_t cur_entry;
  entry_t next_entry;
  entry_t first_entry;
  logic   restart;
  logic   beat_wrap;
  logic   advance;
  logic   tone;
  logic   [1:0] speaker;

  // Sequencer next-state; a tune-select change restarts exactly like reset.
  always_comb begin
    cur_entry    = tune_entry(db_q, step_q);
    next_entry   = tune_entry(db_q, step_q + STEP_W'(1));
    first_entry  = tune_entry(db_sel, '0);
    restart      = rst || (db_sel != db_q);
    beat_wrap    = (beat_cnt_q == CNT_W'(MAX_COUNT - 1));
    advance      = beat_wrap && (beats_left_q == BEATS_W'(1));
    speaker      = (cur_entry.note == '0) ? 2'b00 : {~tone, tone};

    beat_cnt_d   = beat_cnt_q;
    beats_left_d = beats_left_q;
    step_d       = step_q;
    db_d         = db_sel;
    io_out_d     = {2'b00, step_q, speaker};

    if (restart) begin
      beat_cnt_d   = '0;
      step_d       = '0;
      beats_left_d = dur_beats(first_entry.dur);
      io_out_d     = 8'h00;
    end else begin
      beat_cnt_d = beat_wrap ? '0 : beat_cnt_q + CNT_W'(1);
      if (advance) begin
        step_d       = step_q + STEP_W'(1);
        beats_left_d = dur_beats(next_entry.dur);
      end else if (beat_wrap) begin
        beats_left_d = beats_left_q - BEATS_W'(1);
      end
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk) begin
    beat_cnt_q   <= beat_cnt_d;
    beats_left_q <= beats_left_d;
    step_q       <= step_d;
    db_q         <= db_d;
    io_out_q     <= io_out_d;
  end

  tune_tone_gen u_tone_gen (
    .clk       (clk),
    .rst       (rst),
    .i_half    (half_period(cur_entry.note)),
    .i_en      (cur_entry.note != '0),
    .i_restart (restart || advance),
    .o_tone    (tone)
  );

  assign io_out = io_out_q;

endmodule
`default_nettype wire

// File: tb/tb_flygoat_tt02_play_tune.sv
`default_nettype none
// ============================================================================
// Module : tb_flygoat_tt02_play_tune
// Brief  : Self-checking bench for the TT02 tune player (MAX_COUNT=100).
// Rev    : 1.0  initial release
// ============================================================================
module tb_flygoat_tt02_play_tune;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] sel  = 2'd3;
  logic [3:0] junk = 4'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [7:0] trace [0:299];
  logic [7:0] exp_v;

  int checks   = 0;
  int failures = 0;

  assign io_in = {junk, sel, rst, clk};

  flygoat_tt02_play_tune #(.MAX_COUNT(100)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable for sampling on the falling edge.
  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected io_out k samples after a restart edge, from the tune tables.
  function automatic logic [7:0] model_out(input int tsel, input int k);
    int m, len, stp, pos, note, t;
    logic [3:0] s4;
    logic [1:0] spk;
    m    = k - 1;
    len  = (tsel == 1) ? 200 : 100;
    stp  = (m / len) % 16;
    pos  = m % len;
    case (tsel)
      0:       note = (stp == 15) ? 0 : stp + 1;
      1:       note = (stp == 15) ? 0 : 15 - stp;
      2:       note = (stp % 2 == 0) ? 1 : 8;
      default: note = 8;
    endcase
    if (note == 0) begin
      spk = 2'b00;
    end else begin
      t   = (pos / (34 - 2 * note)) % 2;
      spk = (t == 1) ? 2'b01 : 2'b10;
    end
    s4 = stp[3:0];
    return {2'b00, s4, spk};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    sel = 2'd3;
    for (int i = 0; i < 2; i++) begin
      step_clk();
      checks++;
      if (io_out !== 8'h00) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=00", i, io_out);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_tune3();
    for (int k = 1; k <= 300; k++) begin
      step_clk();
      exp_v = model_out(3, k);
      trace[k-1] = io_out;
      checks++;
      if (io_out !== exp_v) begin
        failures++;
        $display("FAIL tune3 k=%0d got=%h exp=%h", k, io_out, exp_v);
      end
      if (k == 1 || k == 19 || k == 101) begin
        exp_v = (k == 1) ? 8'h02 : (k == 19) ? 8'h01 : 8'h06;
        checks++;
        if (io_out !== exp_v) begin
          failures++;
          $display("FAIL tune3_point k=%0d got=%h exp=%h", k, io_out, exp_v);
        end
      end
    end
  endtask

  task automatic test_tune0();
    rst = 1'b1;
    sel = 2'd0;
    step_clk();
    checks++;
    if (io_out !== 8'h00) begin
      failures++;
      $display("FAIL tune0_reset got=%h exp=00", io_out);
    end
    rst = 1'b0;
    for (int k = 1; k <= 1750; k++) begin
      step_clk();
      exp_v = model_out(0, k);
      checks++;
      if (io_out !== exp_v) begin
        failures++;
        $display("FAIL tune0 k=%0d got=%h exp=%h", k, io_out, exp_v);
      end
      if (k == 1401 || k == 1405 || k == 1501 || k == 1601) begin
        exp_v = (k == 1401) ? 8'h3A : (k == 1405) ? 8'h39 : (k == 1501) ? 8'h3C : 8'h02;
        checks++;
        if (io_out !== exp_v) begin
          failures++;
          $display("FAIL tune0_point k=%0d got=%h exp=%h", k, io_out, exp_v);
        end
      end
    end
  endtask

  task automatic test_tune1();
    sel = 2'd1;
    step_clk();
    checks++;
    if (io_out !== 8'h00) begin
      failures++;
      $display("FAIL tune1_restart got=%h exp=00", io_out);
    end
    for (int k = 1; k <= 3300; k++) begin
      step_clk();
      exp_v = model_out(1, k);
      checks++;
      if (io_out !== exp_v) begin
        failures++;
        $display("FAIL tune1 k=%0d got=%h exp=%h", k, io_out, exp_v);
      end
      if (k == 5 || k == 201 || k == 2801 || k == 2833) begin
        exp_v = (k == 5) ? 8'h01 : (k == 201) ? 8'h06 : (k == 2801) ? 8'h3A : 8'h39;
        checks++;
        if (io_out !== exp_v) begin
          failures++;
          $display("FAIL tune1_point k=%0d got=%h exp=%h", k, io_out, exp_v);
        end
      end
    end
  endtask

  task automatic test_switch();
    sel = 2'd0;
    step_clk();
    checks++;
    if (io_out !== 8'h00) begin
      failures++;
      $display("FAIL switch_to0 got=%h exp=00", io_out);
    end
    for (int k = 1; k <= 550; k++) begin
      step_clk();
      exp_v = model_out(0, k);
      checks++;
      if (io_out !== exp_v) begin
        failures++;
        $display("FAIL switch_t0 k=%0d got=%h exp=%h", k, io_out, exp_v);
      end
    end
    sel = 2'd2;
    step_clk();
    checks++;
    if (io_out !== 8'h00) begin
      failures++;
      $display("FAIL switch_to2 got=%h exp=00", io_out);
    end
    for (int k = 1; k <= 400; k++) begin
      step_clk();
      exp_v = model_out(2, k);
      checks++;
      if (io_out !== exp_v) begin
        failures++;
        $display("FAIL switch_t2 k=%0d got=%h exp=%h", k, io_out, exp_v);
      end
      if (k == 33 || k == 101 || k == 119) begin
        exp_v = (k == 33) ? 8'h01 : (k == 101) ? 8'h06 : 8'h05;
        checks++;
        if (io_out !== exp_v) begin
          failures++;
          $display("FAIL switch_point k=%0d got=%h exp=%h", k, io_out, exp_v);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 2'd3;
    step_clk();
    for (int k = 1; k <= 150; k++) begin
      step_clk();
      exp_v = model_out(3, k);
      checks++;
      if (io_out !== exp_v) begin
        failures++;
        $display("FAIL mid_pre k=%0d got=%h exp=%h", k, io_out, exp_v);
      end
    end
    rst = 1'b1;
    step_clk();
    checks++;
    if (io_out !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=00", io_out);
    end
    rst = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      junk = 4'($urandom);
      step_clk();
      checks++;
      if (io_out !== trace[k-1]) begin
        failures++;
        $display("FAIL replay k=%0d got=%h exp=%h", k, io_out, trace[k-1]);
      end
    end
    junk = 4'd0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_tune3();
    test_tune0();
    test_tune1();
    test_switch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
